// File: rtl/mul_datapath.sv
// Shift-free multiply datapath: operand register A, down-counter B and accumulator P.
// Optional sticky overflow flag on the accumulator, enabled by defining MUL_DATAPATH_OVF_EN.
module mul_datapath #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             LdA,
  input  logic             LdB,
  input  logic             LdP,
  input  logic             clrP,
  input  logic             decB,
  input  logic [WIDTH-1:0] data_in,
  output logic             eqz,
  output logic [WIDTH-1:0] product
`ifdef MUL_DATAPATH_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] sum;

`ifdef MUL_DATAPATH_OVF_EN
  logic ovf_q, ovf_d;
  logic carry;

  assign {carry, sum} = {1'b0, p_q} + {1'b0, a_q};
  assign ovf = ovf_q;
`else
  assign sum = p_q + a_q;
`endif

  // eqz comes straight from the register so both gating and the controller see pre-edge B.
  assign eqz     = (b_q == '0);
  assign product = p_q;

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    p_d = p_q;
`ifdef MUL_DATAPATH_OVF_EN
    ovf_d = ovf_q;
`endif

    if (LdA) begin
      a_d = data_in;
    end

    if (LdB) begin
      b_d = data_in;
    end else if (decB && !eqz) begin
      b_d = b_q - 1'b1;
    end

    if (clrP) begin
      p_d = '0;
`ifdef MUL_DATAPATH_OVF_EN
      ovf_d = 1'b0;
`endif
    end else if (LdP && !eqz) begin
      p_d = sum;
`ifdef MUL_DATAPATH_OVF_EN
      if (carry) begin
        ovf_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
`ifdef MUL_DATAPATH_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      p_q <= p_d;
`ifdef MUL_DATAPATH_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_mul_datapath.sv
// Self-checking bench for mul_datapath: directed multiply scenarios plus random control traffic
// compared against an arithmetic reference model.
module tb_mul_datapath;
  localparam int W = 16;
  localparam longint Mod = longint'(1) << W;

  logic         clk = 1'b0;
  logic         rst, LdA, LdB, LdP, clrP, decB;
  logic [W-1:0] data_in;
  logic         eqz;
  logic [W-1:0] product;
`ifdef MUL_DATAPATH_OVF_EN
  logic         ovf;
`endif

  mul_datapath #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .LdA    (LdA),
    .LdB    (LdB),
    .LdP    (LdP),
    .clrP   (clrP),
    .decB   (decB),
    .data_in(data_in),
    .eqz    (eqz),
    .product(product)
`ifdef MUL_DATAPATH_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: plain integers.
  longint ma = 0, mb = 0, mp = 0;
  bit     movf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    {rst, LdA, LdB, LdP, clrP, decB} = '0;
  endtask

  // Advance the model by one clock using the current inputs, then clock the DUT and compare.
  task automatic step(input string tag);
    longint na = ma, nb = mb, np = mp, s;
    bit     novf = movf;
    if (rst) begin
      na = 0; nb = 0; np = 0; novf = 1'b0;
    end else begin
      if (LdA) na = data_in;
      if (LdB) nb = data_in;
      else if (decB && mb != 0) nb = mb - 1;
      if (clrP) begin
        np = 0; novf = 1'b0;
      end else if (LdP && mb != 0) begin
        s = mp + ma;
        if (s >= Mod) novf = 1'b1;
        np = s % Mod;
      end
    end
    ma = na; mb = nb; mp = np; movf = novf;
    @(posedge clk);
    #1;
    check({tag, ".product"}, 32'(product), 32'(mp));
    check({tag, ".eqz"}, 32'(eqz), 32'(mb == 0));
`ifdef MUL_DATAPATH_OVF_EN
    check({tag, ".ovf"}, 32'(ovf), 32'(movf));
`endif
  endtask

  // Full controller sequence; final product must equal the true product mod 2^W.
  task automatic run_mul(input string tag, input longint a, input longint b);
    int n;
    idle(); LdA = 1'b1; data_in = W'(a); step({tag, ".lda"});
    idle(); LdB = 1'b1; clrP = 1'b1; data_in = W'(b); step({tag, ".ldb"});
    check({tag, ".eqz_after_ldb"}, 32'(eqz), 32'(b == 0));
    idle(); LdP = 1'b1; decB = 1'b1;
    n = 0;
    do begin
      step({tag, ".acc"});
      n++;
    end while (!eqz && n < int'(b) + 2);
    check({tag, ".done"}, 32'(eqz), 32'd1);
    check({tag, ".result"}, 32'(product), 32'((a * b) % Mod));
    idle(); step({tag, ".hold"});
    check({tag, ".held"}, 32'(product), 32'((a * b) % Mod));
  endtask

  initial begin
    idle();
    data_in = '0;
    rst = 1'b1; LdA = 1'b1; LdB = 1'b1; data_in = 16'h1234;
    step("reset");
    check("reset.product", 32'(product), 32'd0);
    check("reset.eqz", 32'(eqz), 32'd1);

    run_mul("mul5x3", 5, 3);
    check("mul5x3.abs", 32'(product), 32'd15);
    run_mul("mul7x0", 7, 0);
    check("mul7x0.abs", 32'(product), 32'd0);
    run_mul("wrap", 16'h8000, 3);
    check("wrap.abs", 32'(product), 32'h8000);
`ifdef MUL_DATAPATH_OVF_EN
    check("wrap.ovf_sticky", 32'(ovf), 32'd1);
    idle(); clrP = 1'b1; LdP = 1'b1; step("ovf_clr");
    check("ovf_clr.ovf", 32'(ovf), 32'd0);
`endif

    // Reset in the middle of a multiplication, with controls also active.
    idle(); LdA = 1'b1; data_in = 16'd4; step("abort.lda");
    idle(); LdB = 1'b1; clrP = 1'b1; data_in = 16'd10; step("abort.ldb");
    idle(); LdP = 1'b1; decB = 1'b1;
    for (int i = 0; i < 5; i++) step("abort.acc");
    check("abort.partial", 32'(product), 32'd20);
    rst = 1'b1; LdA = 1'b1; LdB = 1'b1; data_in = 16'h00ff; step("abort.rst");
    check("abort.product", 32'(product), 32'd0);
    check("abort.eqz", 32'(eqz), 32'd1);
    // A must have been cleared: accumulating it leaves P at 0.
    idle(); LdB = 1'b1; clrP = 1'b1; data_in = 16'd2; step("abort.ldb2");
    idle(); LdP = 1'b1; decB = 1'b1; step("abort.acc2"); step("abort.acc2");
    check("abort.a_zero", 32'(product), 32'd0);

    // Priority: LdB over decB, clrP over LdP.
    run_mul("mul10x2", 10, 2);
    idle(); LdB = 1'b1; decB = 1'b1; data_in = 16'd9; step("prio.ldb");
    idle(); clrP = 1'b1; LdP = 1'b1; step("prio.clrp");
    check("prio.p_zero", 32'(product), 32'd0);
    idle(); LdP = 1'b1; decB = 1'b1;
    for (int i = 0; i < 8; i++) step("prio.count");
    check("prio.b_not_zero", 32'(eqz), 32'd0);
    step("prio.count");
    check("prio.b_was_9", 32'(product), 32'd90);
    check("prio.eqz", 32'(eqz), 32'd1);

    for (int t = 0; t < 6; t++) begin
      run_mul("rand_mul", longint'($urandom_range(0, 16'hffff)), longint'($urandom_range(0, 12)));
    end

    // Random control traffic, including rst and overlapping loads.
    for (int t = 0; t < 300; t++) begin
      rst  = ($urandom_range(0, 31) == 0);
      LdA  = 1'($urandom);
      LdB  = ($urandom_range(0, 3) == 0);
      LdP  = 1'($urandom);
      clrP = ($urandom_range(0, 7) == 0);
      decB = 1'($urandom);
      data_in = $urandom_range(0, 1) ? W'($urandom_range(0, 6)) : W'($urandom);
      step("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_datapath.md
MUL_DATAPATH -- requirements
Module: mul_datapath

Interface
REQ-001 Parameter WIDTH, default 16: width of data_in, A, B and P.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 LdA  input  1  load data_in into register A.
REQ-005 LdB  input  1  load data_in into down-counter B.
REQ-006 LdP  input  1  accumulate: P <= P + A.
REQ-007 clrP  input  1  clear P to 0.
REQ-008 decB  input  1  decrement B by 1.
REQ-009 data_in  input  WIDTH  operand bus shared by A and B loads.
REQ-010 eqz  output  1  combinational, high when B == 0.
REQ-011 product  output  WIDTH  current value of P, driven directly from register.
REQ-012 ovf  output  1  sticky accumulate-overflow flag; present only under REQ-028.

Function
REQ-013 A SHALL load data_in on a clk edge with LdA=1; otherwise hold.
REQ-014 B SHALL load data_in on a clk edge with LdB=1; LdB SHALL take priority over decB in the same cycle.
REQ-015 B SHALL decrement by 1 on a clk edge with decB=1, LdB=0 and eqz=0; B SHALL hold when eqz=1 (no underflow past 0).
REQ-016 P SHALL clear to 0 on a clk edge with clrP=1; clrP SHALL take priority over LdP.
REQ-017 P SHALL update to (P + A) mod 2^WIDTH on a clk edge with LdP=1, clrP=0 and eqz=0; P SHALL hold when eqz=1.
REQ-018 eqz gating (REQ-015, REQ-017) SHALL use the pre-edge value of B, so the terminating cycle from the controller adds nothing.
REQ-019 LdA and LdB asserted together SHALL both load the same data_in value.
REQ-020 Load-to-output latency: one clk edge; eqz SHALL reflect a newly loaded B in the same cycle the register updates, with no added delay.
REQ-021 Expected control sequence: LdA cycle; LdB+clrP cycle; LdP+decB cycles until eqz=1; product then equals A*B mod 2^WIDTH and SHALL hold while all controls are 0.
REQ-022 B loaded with 0: eqz=1 immediately; the following LdP+decB cycle SHALL leave P=0 and B=0.
REQ-023 Inputs asserted with no datapath effect (e.g. decB with eqz=1) SHALL be silently ignored; no error state.

Reset
REQ-024 rst=1 on a clk edge SHALL set A=0, B=0, P=0 (and ovf=0 when present); rst SHALL override every control input.
REQ-025 After reset, eqz=1 and product=0.
REQ-026 rst mid-multiplication SHALL abort it: all registers 0 on the next edge; no partial result retained.
REQ-027 Control inputs during the rst cycle SHALL have no effect.

Configuration
REQ-028 Macro MUL_DATAPATH_OVF_EN defined: ovf port exists; ovf SHALL set on any accepted accumulate (REQ-017) whose true sum exceeds 2^WIDTH-1, SHALL hold until clrP=1 or rst=1, and clrP SHALL clear it even if LdP is also 1.
REQ-029 Macro undefined: no ovf port, no carry logic; all other behaviour identical.

Verification
REQ-030 rst; LdA with data_in=5; LdB+clrP with data_in=3; LdP+decB until eqz -> product=15 after 3 accumulates, B=0, eqz=1, product holds 15 with controls idle.
REQ-031 A=7, B=0 via same sequence -> eqz=1 right after LdB; one LdP+decB cycle -> product=0, B=0 (no underflow to 0xFFFF).
REQ-032 WIDTH=16, A=0x8000, B=3 -> product=0x8000 (wraps mod 2^16); with MUL_DATAPATH_OVF_EN, ovf=1 after second accumulate and stays 1 until next clrP.
REQ-033 A=4, B=10, assert rst after 5 accumulates -> next edge A=0, B=0, product=0, eqz=1 (ovf=0).
REQ-034 LdB and decB together with data_in=9 -> B=9; clrP and LdP together with P=20 -> P=0.
